// File: rtl/apb_i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_i2c_req_arbiter
//   Shares the single APB slave port of the i2c controller between NUM_REQ
//   requesters. Round-robin arbitration, one two-phase APB transfer per
//   grant, and a PREADY timeout guard so that a dead slave cannot lock the bus.
//
// Ports
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   req_vld/req_write        per-requester request and direction (1 = write)
//   req_addr/req_wdata       packed payload, requester i at [i*DATA_W +: DATA_W]
//   req_rdy                  one-hot accept pulse (combinational, IDLE only)
//   rsp_vld                  one-hot completion pulse to the granted requester
//   rsp_rdata/rsp_err        shared response data/error, valid with rsp_vld
//   PADDR..PENABLE           APB master outputs
//   PRDATA/PREADY/PSLVERR    APB slave responses
//   busy                     high in every state except IDLE
//   grant_id                 current or last granted requester
//   timeout                  one-cycle pulse when a transfer is aborted
//   dbg_state_o              FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP)
//
// Handshake: a request transfers on the rising edge where req_vld[i] and
// req_rdy[i] are both high; the requester holds payload stable until then.
// A response is delivered in the single cycle rsp_vld[i] is high; there is
// no back-pressure on the response side.
// ---------------------------------------------------------------------------
module apb_i2c_req_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic                      PWRITE,
    output logic                      PSELx,
    output logic                      PENABLE,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      timeout,
    output logic [1:0]                dbg_state_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                pwrite_q;
    logic                psel_q;
    logic                penable_q;
    logic [NUM_REQ-1:0]  rsp_vld_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                timeout_q;

    // Round-robin pick: first requester at or above rr_ptr, wrapping.
    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W:0]      cand;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req_vld[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer to the requester after the one just served.
    logic [IDX_W:0]      nxt_sum;
    logic [IDX_W-1:0]    rr_next;

    assign nxt_sum = {1'b0, grant_q} + (IDX_W+1)'(1);
    assign rr_next = (nxt_sum >= (IDX_W+1)'(NUM_REQ)) ? '0 : nxt_sum[IDX_W-1:0];

    always_comb begin
        req_rdy = '0;
        if (state_q == S_IDLE && found) begin
            req_rdy[pick] = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rsp_vld_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            rsp_vld_q <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    if (found) begin
                        grant_q  <= pick;
                        pwrite_q <= req_write[pick];
                        paddr_q  <= req_addr[int'(pick)*DATA_W +: DATA_W];
                        pwdata_q <= req_wdata[int'(pick)*DATA_W +: DATA_W];
                        psel_q   <= 1'b1;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // PREADY is tested first so it wins over a coinciding expiry.
                    if (PREADY) begin
                        rdata_q   <= pwrite_q ? '0 : PRDATA;
                        err_q     <= PSLVERR;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rsp_vld_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                        state_q   <= S_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC-1)) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rsp_vld_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                        state_q   <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                    cnt_q    <= '0;
                    rr_ptr_q <= rr_next;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_vld     = rsp_vld_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign busy        = (state_q != S_IDLE);
    assign grant_id    = grant_q;
    assign timeout     = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_i2c_req_arbiter
//   Directed bench for apb_i2c_req_arbiter (NUM_REQ=2, DATA_W=32,
//   TIMEOUT_CYC=8). The driver issues requests and pushes the hand-computed
//   response into exp_q; a monitor pops and compares on every rsp_vld.
// ---------------------------------------------------------------------------
module tb_apb_i2c_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int TO_CYC  = 8;
    localparam int IDX_W   = 1;
    localparam int EW      = 2 + NUM_REQ + DATA_W;

    // ---------------- clock / reset ----------------
    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    logic [NUM_REQ-1:0]        req_vld = '0;
    logic [NUM_REQ-1:0]        req_write = '0;
    logic [NUM_REQ*DATA_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]        req_rdy;
    logic [NUM_REQ-1:0]        rsp_vld;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [DATA_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic                      PWRITE;
    logic                      PSELx;
    logic                      PENABLE;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;
    logic                      busy;
    logic [IDX_W-1:0]          grant_id;
    logic                      timeout;
    logic [1:0]                dbg_state;

    apb_i2c_req_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_vld(req_vld), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdy(req_rdy), .rsp_vld(rsp_vld),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSELx(PSELx), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .busy(busy), .grant_id(grant_id), .timeout(timeout),
        .dbg_state_o(dbg_state)
    );

    // ---------------- APB slave model ----------------
    int          ws = 0;
    bit          hang = 1'b0;
    bit          serr = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          acc_cnt;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                         acc_cnt <= 0;
        else if (PSELx && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                                  acc_cnt <= 0;
    end

    assign PREADY  = PSELx && PENABLE && !hang && (acc_cnt >= ws);
    assign PSLVERR = PREADY && serr;
    assign PRDATA  = PREADY ? slv_rdata : '0;

    // ---------------- scoreboard ----------------
    int n_chk = 0;
    int n_pass = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input int idx, input bit to, input bit err, input logic [31:0] rd);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        exp_q.push_back({to, err, oh, rd});
    endtask

    always @(negedge PCLK) begin
        if (PRESETn && rsp_vld != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_vld), 64'(0));
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("rsp_vld",   64'(rsp_vld),   64'(e[DATA_W +: NUM_REQ]));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e[DATA_W-1:0]));
                check("rsp_err",   64'(rsp_err),   64'(e[EW-2]));
                check("timeout",   64'(timeout),   64'(e[EW-1]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int idx, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        req_vld[idx]                 = 1'b1;
        req_write[idx]               = wr;
        req_addr[idx*DATA_W +: DATA_W]  = addr;
        req_wdata[idx*DATA_W +: DATA_W] = wd;
    endtask

    // Called at the negedge of cycle 1; returns the cycle index of rsp_vld.
    task automatic wait_rsp(output int n);
        n = 1;
        while (rsp_vld == '0 && n < 100) begin
            @(negedge PCLK);
            n++;
        end
    endtask

    task automatic do_reset();
        req_vld = '0;
        hang = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    // One isolated transfer with hand-computed response and latency.
    task automatic xfer(input string name, input int idx, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int t_ws, input bit t_hang, input bit t_err,
                        input logic [31:0] t_rd, input bit e_to, input bit e_err,
                        input logic [31:0] e_rd, input int e_lat);
        int n;
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        @(negedge PCLK);
        ws = t_ws; hang = t_hang; serr = t_err; slv_rdata = t_rd;
        set_req(idx, wr, addr, wd);
        #1;
        check({name, "_rdy"}, 64'(req_rdy), 64'(oh));
        push_exp(idx, e_to, e_err, e_rd);
        @(negedge PCLK);
        req_vld = '0;
        wait_rsp(n);
        check({name, "_lat"}, 64'(n), 64'(e_lat));
        check({name, "_psel_resp"}, 64'(PSELx), 64'(0));
        check({name, "_gid"}, 64'(grant_id), 64'(idx));
        @(negedge PCLK);
        check({name, "_idle"}, 64'(busy), 64'(0));
        check({name, "_rdata_clr"}, 64'(rsp_rdata), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int nh;
        int last;
        logic [NUM_REQ-1:0] oh;

        // reset values
        @(negedge PCLK);
        check("rst_outs", {rsp_vld, rsp_err, PWRITE, PSELx, PENABLE, busy, grant_id, timeout, dbg_state},
              64'(0));
        check("rst_bus", {PADDR, PWDATA}, 64'(0));
        check("rst_rdata", 64'(rsp_rdata), 64'(0));
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("rst_rdy", 64'(req_rdy), 64'(0));

        // single write, zero wait states, cycle by cycle
        ws = 0; hang = 0; serr = 0;
        @(negedge PCLK);
        set_req(0, 1'b1, 32'h04, 32'hA5);
        #1;
        check("w_rdy_c0", 64'(req_rdy), 64'(2'b01));
        push_exp(0, 1'b0, 1'b0, 32'h0);
        @(negedge PCLK);
        req_vld = '0;
        check("w_c1_sel_en", {PSELx, PENABLE}, 64'(2'b10));
        check("w_c1_bus", {PWRITE, PADDR, PWDATA}, {1'b1, 32'h04, 32'hA5});
        @(negedge PCLK);
        check("w_c2_sel_en", {PSELx, PENABLE}, 64'(2'b11));
        @(negedge PCLK);
        check("w_c3_rsp", 64'(rsp_vld), 64'(2'b01));
        check("w_c3_sel_en", {PSELx, PENABLE}, 64'(2'b00));
        @(negedge PCLK);
        check("w_c4_idle", 64'(busy), 64'(0));
        check("w_c4_paddr_hold", 64'(PADDR), 64'h04);

        // read with 3 wait states, response at cycle 6
        xfer("rd_ws3", 1, 1'b0, 32'h08, 32'h0, 3, 1'b0, 1'b0, 32'hDEADBEEF,
             1'b0, 1'b0, 32'hDEADBEEF, 6);

        // slave error on a write
        xfer("slverr", 0, 1'b1, 32'h0C, 32'h55, 0, 1'b0, 1'b1, 32'h0,
             1'b0, 1'b1, 32'h0, 3);

        // timeout: PREADY never comes; 8 ACCESS cycles, response at cycle 10
        xfer("tmo", 1, 1'b0, 32'h20, 32'h0, 0, 1'b1, 1'b0, 32'h77,
             1'b1, 1'b1, 32'h0, 10);

        // normal read right after the timeout
        xfer("post_tmo", 0, 1'b0, 32'h24, 32'h0, 0, 1'b0, 1'b0, 32'hCAFE0001,
             1'b0, 1'b0, 32'hCAFE0001, 3);

        // reset in ACCESS; rr_ptr is 1 here, so without a proper reset
        // the next simultaneous request would go to requester 1
        @(negedge PCLK);
        hang = 1'b1;
        set_req(1, 1'b0, 32'h30, 32'h0);
        #1;
        check("rst_mid_rdy", 64'(req_rdy), 64'(2'b10));
        @(negedge PCLK);
        req_vld = '0;
        @(negedge PCLK);
        check("rst_mid_access", {PSELx, PENABLE, dbg_state}, 64'(4'b1110));
        #2;
        PRESETn = 1'b0;
        #1;
        check("rst_mid_async", {PSELx, PENABLE, busy}, 64'(0));
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        hang = 1'b0;
        @(negedge PCLK);
        set_req(0, 1'b1, 32'h40, 32'h1);
        set_req(1, 1'b1, 32'h44, 32'h2);
        #1;
        check("rst_rr_ptr0", 64'(req_rdy), 64'(2'b01));
        push_exp(0, 1'b0, 1'b0, 32'h0);
        @(negedge PCLK);
        req_vld = '0;
        wait_rsp(n);
        check("rst_after_lat", 64'(n), 64'(3));
        @(negedge PCLK);

        // fairness: both requesters held for 6 transfers
        do_reset();
        ws = 0; serr = 0; slv_rdata = 32'h12345678;
        set_req(0, 1'b1, 32'h10, 32'h11);
        set_req(1, 1'b0, 32'h14, 32'h0);
        nh = 0; last = 0; n = 0;
        while (nh < 6 && n < 100) begin
            #1;
            if (req_rdy != '0) begin
                oh = '0;
                oh[nh % 2] = 1'b1;
                check("fair_grant", 64'(req_rdy), 64'(oh));
                if (nh > 0) check("fair_gap", 64'(n - last), 64'(4));
                last = n;
                if (nh % 2 == 0) push_exp(0, 1'b0, 1'b0, 32'h0);
                else             push_exp(1, 1'b0, 1'b0, 32'h12345678);
                nh++;
            end
            @(negedge PCLK);
            n++;
        end
        req_vld = '0;
        check("fair_count", 64'(nh), 64'(6));
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        repeat (3) @(negedge PCLK);

        check("sb_empty", 64'(exp_q.size()), 64'(0));
        check("final_idle", 64'(busy), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
